// File: rtl/fft_band_power_avg_if.sv
// rtl/fft_band_power_avg_if.sv - bin input stream and power result stream of fft_band_power_avg
//
// Input stream (master -> slave): in_valid, in_real, in_imag, in_last; in_ready back.
// Output stream (slave -> master): out_valid, out_power, frame_err; out_ready back.
// FFT_BAND_PEAK_EN adds out_peak_idx / out_peak_pwr, qualified by out_valid.
interface fft_band_power_avg_if #(
    parameter int DATA_W = 24,
    parameter int NFFT   = 8,
    parameter int PWR_W  = 2 * DATA_W + $clog2(NFFT)
);
    localparam int LOG2N = $clog2(NFFT);

    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_real;
    logic signed [DATA_W-1:0] in_imag;
    logic                     in_last;
    logic                     out_valid;
    logic                     out_ready;
    logic [PWR_W-1:0]         out_power;
    logic                     frame_err;
`ifdef FFT_BAND_PEAK_EN
    logic [LOG2N-1:0]         out_peak_idx;
    logic [2*DATA_W-1:0]      out_peak_pwr;

    modport master (
        output in_valid, in_real, in_imag, in_last, out_ready,
        input  in_ready, out_valid, out_power, frame_err, out_peak_idx, out_peak_pwr
    );
    modport slave (
        input  in_valid, in_real, in_imag, in_last, out_ready,
        output in_ready, out_valid, out_power, frame_err, out_peak_idx, out_peak_pwr
    );
`else
    modport master (
        output in_valid, in_real, in_imag, in_last, out_ready,
        input  in_ready, out_valid, out_power, frame_err
    );
    modport slave (
        input  in_valid, in_real, in_imag, in_last, out_ready,
        output in_ready, out_valid, out_power, frame_err
    );
`endif
endinterface

// File: rtl/fft_band_power_avg.sv
// rtl/fft_band_power_avg.sv - post-FFT band power detector with 2^n frame averaging
//
// Ports: clk, rst (sync, active-high); cfg_band_lo/cfg_band_hi (inclusive bin band);
// cfg_avg_log2 (frames averaged = 2^value, clamped to AVG_MAX_LOG2);
// bus (slave modport): bin stream in, averaged power out, frame_err pulse.
// Optional macro FFT_BAND_PEAK_EN: peak in-band bin index/power over the averaging period.
module fft_band_power_avg #(
    parameter int DATA_W       = 24,
    parameter int NFFT         = 8,
    parameter int AVG_MAX_LOG2 = 4,
    parameter int PWR_W        = 2 * DATA_W + $clog2(NFFT)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [$clog2(NFFT)-1:0]              cfg_band_lo,
    input  logic [$clog2(NFFT)-1:0]              cfg_band_hi,
    input  logic [$clog2(AVG_MAX_LOG2+1)-1:0]    cfg_avg_log2,
    fft_band_power_avg_if.slave                  bus
);
    localparam int LOG2N = $clog2(NFFT);
    localparam int SQ_W  = 2 * DATA_W;
    localparam int AVG_W = $clog2(AVG_MAX_LOG2 + 1);
    localparam int ACC_W = PWR_W + AVG_MAX_LOG2;
    localparam int CNT_W = AVG_MAX_LOG2 + 1;

    // ST_HOLD: final frame of the period accepted, input blocked until the result is taken.
    typedef enum logic {ST_RUN = 1'b0, ST_HOLD = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [LOG2N-1:0]   bin_idx_q, bin_idx_d;
    logic [CNT_W-1:0]   frames_in_q, frames_in_d;
    logic [LOG2N-1:0]   band_lo_q, band_lo_d, band_hi_q, band_hi_d;
    logic [AVG_W-1:0]   avg_q, avg_d;
    // S1
    logic               s1_valid_q, s1_valid_d, s1_in_band_q, s1_in_band_d;
    logic               s1_end_q, s1_end_d, s1_err_q, s1_err_d, s1_final_q, s1_final_d;
    logic [SQ_W-1:0]    s1_re2_q, s1_re2_d, s1_im2_q, s1_im2_d;
    // S2
    logic               s2_valid_q, s2_valid_d, s2_end_q, s2_end_d;
    logic               s2_err_q, s2_err_d, s2_final_q, s2_final_d;
    logic [SQ_W-1:0]    s2_mag_q, s2_mag_d;
    // S3 and averaging
    logic [PWR_W-1:0]   band_sum_q, band_sum_d, frame_sum_q, frame_sum_d;
    logic               done_q, done_d, final_q, final_d, frame_err_q, frame_err_d;
    logic [ACC_W-1:0]   avg_acc_q, avg_acc_d, acc_n;
    logic               out_valid_q, out_valid_d;
    logic [PWR_W-1:0]   out_power_q, out_power_d, sum_n;

    logic               in_ready, accept, period_start, is_last_bin, beat_err;
    logic               frame_end, good_end, is_final, in_band;
    logic [LOG2N-1:0]   lo_eff, hi_eff;
    logic [AVG_W-1:0]   avg_clamped, avg_eff;
    logic [CNT_W-1:0]   period_len;
    logic signed [SQ_W-1:0] re_ext, im_ext;

    assign in_ready      = (state_q == ST_RUN) && !rst;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_power = out_power_q;
    assign bus.frame_err = frame_err_q;

    // Acceptance-side decode: frame checks and band membership are resolved here so the
    // pipeline only carries flags. Config is live on the first beat of a period, held after.
    always_comb begin
        re_ext       = {{DATA_W{bus.in_real[DATA_W-1]}}, bus.in_real};
        im_ext       = {{DATA_W{bus.in_imag[DATA_W-1]}}, bus.in_imag};
        accept       = bus.in_valid && in_ready;
        avg_clamped  = (cfg_avg_log2 > AVG_W'(AVG_MAX_LOG2)) ? AVG_W'(AVG_MAX_LOG2) : cfg_avg_log2;
        period_start = (frames_in_q == '0) && (bin_idx_q == '0);
        lo_eff       = period_start ? cfg_band_lo : band_lo_q;
        hi_eff       = period_start ? cfg_band_hi : band_hi_q;
        avg_eff      = period_start ? avg_clamped : avg_q;
        is_last_bin  = (bin_idx_q == LOG2N'(NFFT - 1));
        beat_err     = bus.in_last ^ is_last_bin;
        frame_end    = bus.in_last | is_last_bin;
        good_end     = frame_end & ~beat_err;
        period_len   = CNT_W'(1) << avg_eff;
        is_final     = good_end && ((frames_in_q + CNT_W'(1)) == period_len);
        in_band      = (bin_idx_q >= lo_eff) && (bin_idx_q <= hi_eff);
    end

    always_comb begin
        state_d      = state_q;
        bin_idx_d    = bin_idx_q;
        frames_in_d  = frames_in_q;
        band_lo_d    = band_lo_q;
        band_hi_d    = band_hi_q;
        avg_d        = avg_q;
        s1_valid_d   = accept;
        s1_re2_d     = re_ext * re_ext;
        s1_im2_d     = im_ext * im_ext;
        s1_in_band_d = in_band;
        s1_end_d     = frame_end;
        s1_err_d     = beat_err;
        s1_final_d   = is_final;
        if (accept) begin
            if (period_start) begin
                band_lo_d = cfg_band_lo;
                band_hi_d = cfg_band_hi;
                avg_d     = avg_clamped;
            end
            // Any frame end, good or malformed, restarts the bin count.
            bin_idx_d = frame_end ? '0 : bin_idx_q + LOG2N'(1);
            if (good_end) begin
                frames_in_d = is_final ? '0 : frames_in_q + CNT_W'(1);
            end
            if (is_final) begin
                state_d = ST_HOLD;
            end
        end
        if (state_q == ST_HOLD && out_valid_q && bus.out_ready) begin
            state_d = ST_RUN;
        end
    end

    always_comb begin
        s2_valid_d  = s1_valid_q;
        s2_mag_d    = s1_in_band_q ? (s1_re2_q + s1_im2_q) : '0;
        s2_end_d    = s1_end_q;
        s2_err_d    = s1_err_q;
        s2_final_d  = s1_final_q;

        sum_n       = band_sum_q + PWR_W'(s2_mag_q);
        band_sum_d  = band_sum_q;
        frame_sum_d = frame_sum_q;
        done_d      = 1'b0;
        final_d     = 1'b0;
        frame_err_d = 1'b0;
        if (s2_valid_q) begin
            if (s2_end_q) begin
                band_sum_d = '0;
                if (s2_err_q) begin
                    frame_err_d = 1'b1;
                end else begin
                    frame_sum_d = sum_n;
                    done_d      = 1'b1;
                    final_d     = s2_final_q;
                end
            end else begin
                band_sum_d = sum_n;
            end
        end

        acc_n       = avg_acc_q + ACC_W'(frame_sum_q);
        avg_acc_d   = avg_acc_q;
        out_valid_d = out_valid_q;
        out_power_d = out_power_q;
        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
        if (done_q) begin
            if (final_q) begin
                out_power_d = PWR_W'(acc_n >> avg_q);
                out_valid_d = 1'b1;
                avg_acc_d   = '0;
            end else begin
                avg_acc_d   = acc_n;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            bin_idx_q   <= '0;
            frames_in_q <= '0;
            band_lo_q   <= '0;
            band_hi_q   <= '0;
            avg_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_re2_q    <= '0;
            s1_im2_q    <= '0;
            s1_in_band_q <= 1'b0;
            s1_end_q    <= 1'b0;
            s1_err_q    <= 1'b0;
            s1_final_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_mag_q    <= '0;
            s2_end_q    <= 1'b0;
            s2_err_q    <= 1'b0;
            s2_final_q  <= 1'b0;
            band_sum_q  <= '0;
            frame_sum_q <= '0;
            done_q      <= 1'b0;
            final_q     <= 1'b0;
            frame_err_q <= 1'b0;
            avg_acc_q   <= '0;
            out_valid_q <= 1'b0;
            out_power_q <= '0;
        end else begin
            state_q     <= state_d;
            bin_idx_q   <= bin_idx_d;
            frames_in_q <= frames_in_d;
            band_lo_q   <= band_lo_d;
            band_hi_q   <= band_hi_d;
            avg_q       <= avg_d;
            s1_valid_q  <= s1_valid_d;
            s1_re2_q    <= s1_re2_d;
            s1_im2_q    <= s1_im2_d;
            s1_in_band_q <= s1_in_band_d;
            s1_end_q    <= s1_end_d;
            s1_err_q    <= s1_err_d;
            s1_final_q  <= s1_final_d;
            s2_valid_q  <= s2_valid_d;
            s2_mag_q    <= s2_mag_d;
            s2_end_q    <= s2_end_d;
            s2_err_q    <= s2_err_d;
            s2_final_q  <= s2_final_d;
            band_sum_q  <= band_sum_d;
            frame_sum_q <= frame_sum_d;
            done_q      <= done_d;
            final_q     <= final_d;
            frame_err_q <= frame_err_d;
            avg_acc_q   <= avg_acc_d;
            out_valid_q <= out_valid_d;
            out_power_q <= out_power_d;
        end
    end

`ifdef FFT_BAND_PEAK_EN
    // Per-frame peak is kept apart from the period peak so a malformed frame can be
    // discarded. Strict '>' comparisons give lowest index / earliest frame on ties.
    logic [LOG2N-1:0] s1_idx_q, s1_idx_d, s2_idx_q, s2_idx_d;
    logic [LOG2N-1:0] fpk_idx_q, fpk_idx_d, fdone_idx_q, fdone_idx_d, ppk_idx_q, ppk_idx_d;
    logic [LOG2N-1:0] opk_idx_q, opk_idx_d, cand_idx, merge_idx;
    logic [SQ_W-1:0]  fpk_pwr_q, fpk_pwr_d, fdone_pwr_q, fdone_pwr_d, ppk_pwr_q, ppk_pwr_d;
    logic [SQ_W-1:0]  opk_pwr_q, opk_pwr_d, cand_pwr, merge_pwr;

    assign bus.out_peak_idx = opk_idx_q;
    assign bus.out_peak_pwr = opk_pwr_q;

    always_comb begin
        s1_idx_d    = bin_idx_q;
        s2_idx_d    = s1_idx_q;
        fpk_idx_d   = fpk_idx_q;
        fpk_pwr_d   = fpk_pwr_q;
        fdone_idx_d = fdone_idx_q;
        fdone_pwr_d = fdone_pwr_q;
        ppk_idx_d   = ppk_idx_q;
        ppk_pwr_d   = ppk_pwr_q;
        opk_idx_d   = opk_idx_q;
        opk_pwr_d   = opk_pwr_q;
        // Out-of-band bins arrive with mag 0 and can never beat the running peak.
        cand_idx    = (s2_mag_q > fpk_pwr_q) ? s2_idx_q : fpk_idx_q;
        cand_pwr    = (s2_mag_q > fpk_pwr_q) ? s2_mag_q : fpk_pwr_q;
        merge_idx   = (fdone_pwr_q > ppk_pwr_q) ? fdone_idx_q : ppk_idx_q;
        merge_pwr   = (fdone_pwr_q > ppk_pwr_q) ? fdone_pwr_q : ppk_pwr_q;
        if (s2_valid_q) begin
            if (s2_end_q) begin
                fdone_idx_d = cand_idx;
                fdone_pwr_d = cand_pwr;
                fpk_idx_d   = '0;
                fpk_pwr_d   = '0;
            end else begin
                fpk_idx_d   = cand_idx;
                fpk_pwr_d   = cand_pwr;
            end
        end
        if (done_q) begin
            if (final_q) begin
                opk_idx_d = merge_idx;
                opk_pwr_d = merge_pwr;
                ppk_idx_d = '0;
                ppk_pwr_d = '0;
            end else begin
                ppk_idx_d = merge_idx;
                ppk_pwr_d = merge_pwr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_idx_q    <= '0;
            s2_idx_q    <= '0;
            fpk_idx_q   <= '0;
            fpk_pwr_q   <= '0;
            fdone_idx_q <= '0;
            fdone_pwr_q <= '0;
            ppk_idx_q   <= '0;
            ppk_pwr_q   <= '0;
            opk_idx_q   <= '0;
            opk_pwr_q   <= '0;
        end else begin
            s1_idx_q    <= s1_idx_d;
            s2_idx_q    <= s2_idx_d;
            fpk_idx_q   <= fpk_idx_d;
            fpk_pwr_q   <= fpk_pwr_d;
            fdone_idx_q <= fdone_idx_d;
            fdone_pwr_q <= fdone_pwr_d;
            ppk_idx_q   <= ppk_idx_d;
            ppk_pwr_q   <= ppk_pwr_d;
            opk_idx_q   <= opk_idx_d;
            opk_pwr_q   <= opk_pwr_d;
        end
    end
`endif
endmodule

// File: tb/tb_fft_band_power_avg.sv
// tb/tb_fft_band_power_avg.sv - directed self-checking bench for fft_band_power_avg
module tb_fft_band_power_avg;
    localparam int DATA_W       = 24;
    localparam int NFFT         = 8;
    localparam int AVG_MAX_LOG2 = 4;
    localparam int PWR_W        = 2 * DATA_W + 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] cfg_band_lo = '0;
    logic [2:0] cfg_band_hi = '0;
    logic [2:0] cfg_avg_log2 = '0;

    fft_band_power_avg_if #(.DATA_W(DATA_W), .NFFT(NFFT), .PWR_W(PWR_W)) bus ();

    fft_band_power_avg #(
        .DATA_W(DATA_W), .NFFT(NFFT), .AVG_MAX_LOG2(AVG_MAX_LOG2), .PWR_W(PWR_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cfg_band_lo(cfg_band_lo),
        .cfg_band_hi(cfg_band_hi),
        .cfg_avg_log2(cfg_avg_log2),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int pcyc = 0;
    always @(posedge clk) pcyc <= pcyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int err_pulses = 0;
    int err_cyc    = -1;
    int t_acc      = 0;
    logic signed [DATA_W-1:0] re_v [NFFT];
    logic signed [DATA_W-1:0] im_v [NFFT];

    always @(negedge clk) begin
        if (bus.frame_err === 1'b1) begin
            err_pulses++;
            err_cyc = pcyc;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic fill(input logic signed [DATA_W-1:0] re, input logic signed [DATA_W-1:0] im);
        for (int k = 0; k < NFFT; k++) begin
            re_v[k] = re;
            im_v[k] = im;
        end
    endtask

    task automatic send_beat(input logic signed [DATA_W-1:0] re, input logic signed [DATA_W-1:0] im,
                             input logic last);
        bit done = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_real  = re;
        bus.in_imag  = im;
        bus.in_last  = last;
        for (int i = 0; i < 200 && !done; i++) begin
            if (bus.in_ready === 1'b1) begin
                t_acc = pcyc;
                done  = 1'b1;
                @(posedge clk);
            end else begin
                @(negedge clk);
            end
        end
        if (!done) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_frame(input int n, input bit with_last);
        for (int k = 0; k < n; k++) send_beat(re_v[k], im_v[k], with_last && (k == n - 1));
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_result(input string tag, input logic [63:0] exp, input bit chk_lat);
        bit seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        chk({tag, "_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            if (chk_lat) chk({tag, "_lat"}, 64'(pcyc - t_acc), 64'd4);
            chk({tag, "_pwr"}, 64'(bus.out_power), exp);
        end
    endtask

    task automatic take_result(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, "_ov_drop"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_rdy_back"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
        logic [63:0] big;
        bus.in_valid  = 1'b0;
        bus.in_real   = '0;
        bus.in_imag   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ov", 64'(bus.out_valid), 64'd0);
        chk("rst_rdy", 64'(bus.in_ready), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_rdy", 64'(bus.in_ready), 64'd1);
        chk("post_rst_ov", 64'(bus.out_valid), 64'd0);
        chk("post_rst_err", 64'(bus.frame_err), 64'd0);
        chk("post_rst_pwr", 64'(bus.out_power), 64'd0);

        // T1: band 0..3, re=k+1 -> 30, latency 4
        cfg_band_lo = 3'd0; cfg_band_hi = 3'd3; cfg_avg_log2 = 3'd0;
        for (int k = 0; k < NFFT; k++) begin
            re_v[k] = 24'(k + 1);
            im_v[k] = '0;
        end
        send_frame(NFFT, 1'b1);
        idle();
        chk("t1_rdy_low", 64'(bus.in_ready), 64'd0);
        wait_result("t1", 64'd30, 1'b1);
        take_result("t1");

        // T2: band 4..7, re=im=-2^23 -> 2^49
        cfg_band_lo = 3'd4; cfg_band_hi = 3'd7;
        fill(24'sh800000, 24'sh800000);
        send_frame(NFFT, 1'b1);
        idle();
        big = 64'd1 << 49;
        wait_result("t2", big, 1'b1);
        take_result("t2");

        // T3: avg 4 frames, band 2..2, bin2 re = 1..4 -> 7
        cfg_band_lo = 3'd2; cfg_band_hi = 3'd2; cfg_avg_log2 = 3'd2;
        for (int f = 1; f <= 4; f++) begin
            fill(24'sd5, 24'sd3);
            re_v[2] = 24'(f);
            im_v[2] = '0;
            send_frame(NFFT, 1'b1);
            if (f == 3) begin
                idle();
                chk("t3_rdy_mid", 64'(bus.in_ready), 64'd1);
                repeat (6) @(negedge clk);
                chk("t3_no_early", 64'(bus.out_valid), 64'd0);
            end
        end
        idle();
        chk("t3_rdy_low", 64'(bus.in_ready), 64'd0);
        wait_result("t3", 64'd7, 1'b1);
        repeat (3) @(negedge clk);
        chk("t3_rdy_hold", 64'(bus.in_ready), 64'd0);
        take_result("t3");

        // T4: early in_last at bin 5, then good frame (all re=1) -> 8
        cfg_band_lo = 3'd0; cfg_band_hi = 3'd7; cfg_avg_log2 = 3'd0;
        base = err_pulses;
        fill(24'sd9, 24'sd0);
        send_frame(6, 1'b1);
        idle();
        chk("t4_rdy_after_err", 64'(bus.in_ready), 64'd1);
        repeat (5) @(negedge clk);
        chk("t4_err_cnt", 64'(err_pulses - base), 64'd1);
        chk("t4_err_lat", 64'(err_cyc - t_acc), 64'd3);
        chk("t4_no_ov", 64'(bus.out_valid), 64'd0);
        fill(24'sd1, 24'sd0);
        send_frame(NFFT, 1'b1);
        idle();
        wait_result("t4", 64'd8, 1'b1);
        take_result("t4");
        chk("t4_err_total", 64'(err_pulses - base), 64'd1);

        // T4b: bin 7 without in_last, then good frame re=im=1 -> 16
        base = err_pulses;
        fill(24'sd9, 24'sd9);
        send_frame(NFFT, 1'b0);
        idle();
        repeat (5) @(negedge clk);
        chk("t4b_err_cnt", 64'(err_pulses - base), 64'd1);
        fill(24'sd1, 24'sd1);
        send_frame(NFFT, 1'b1);
        idle();
        wait_result("t4b", 64'd16, 1'b1);
        take_result("t4b");

        // T5: out_ready held low with in_valid high; held beat becomes bin 0 of next frame
        cfg_band_lo = 3'd0; cfg_band_hi = 3'd0;
        fill(24'sd2, 24'sd0);
        send_frame(NFFT, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_real  = 24'sd3;
        bus.in_imag  = '0;
        bus.in_last  = 1'b0;
        wait_result("t5a", 64'd4, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t5_hold_ov", 64'(bus.out_valid), 64'd1);
            chk("t5_hold_pwr", 64'(bus.out_power), 64'd4);
            chk("t5_hold_rdy", 64'(bus.in_ready), 64'd0);
        end
        take_result("t5a");
        @(posedge clk);
        for (int k = 1; k < NFFT; k++) send_beat(24'sd0, 24'sd0, k == NFFT - 1);
        idle();
        wait_result("t5b", 64'd9, 1'b1);
        take_result("t5b");

        // T6: reset after 2 of 4 frames, then 4 fresh frames (re=1) -> 8
        cfg_band_lo = 3'd0; cfg_band_hi = 3'd7; cfg_avg_log2 = 3'd2;
        fill(24'sd7, 24'sd0);
        send_frame(NFFT, 1'b1);
        send_frame(NFFT, 1'b1);
        idle();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_rst_ov", 64'(bus.out_valid), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_post_rdy", 64'(bus.in_ready), 64'd1);
        fill(24'sd1, 24'sd0);
        for (int f = 0; f < 4; f++) send_frame(NFFT, 1'b1);
        idle();
        wait_result("t6", 64'd8, 1'b1);
        take_result("t6");

        // T7: empty band (lo=5, hi=2) still produces a zero result
        cfg_band_lo = 3'd5; cfg_band_hi = 3'd2; cfg_avg_log2 = 3'd0;
        fill(24'sd1, 24'sd0);
        send_frame(NFFT, 1'b1);
        idle();
        wait_result("t7", 64'd0, 1'b1);
        take_result("t7");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fft_band_power_avg.md
Name: fft_band_power_avg

Overview:
- Streaming post-FFT power detector for the filtered-power path. Accepts FFT output bins one per cycle over a valid/ready stream, computes |X|^2 per bin, and sums the bins inside a programmable band.
- Averages 2^avg good frames and presents the result on a valid/ready output.
- Parametrised successor of the fixed 8-point, half-band combinational power sum. Adds arbitrary NFFT, arbitrary band edges, frame averaging, framing checks and back-pressure.

Parameters:
- DATA_W, 24: signed width of bin real/imag.
- NFFT, 8: bins per frame; power of 2, at least 4. LOG2N = clog2(NFFT).
- AVG_MAX_LOG2, 4: maximum cfg_avg_log2.
- PWR_W, 2*DATA_W+LOG2N: output width. Internal accumulator width is PWR_W+AVG_MAX_LOG2.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- cfg_band_lo  in  LOG2N  first bin of band, inclusive
- cfg_band_hi  in  LOG2N  last bin of band, inclusive
- cfg_avg_log2  in  clog2(AVG_MAX_LOG2+1)  frames averaged = 2^value; values above AVG_MAX_LOG2 clamp to AVG_MAX_LOG2
- in_valid  in  1  bin beat valid
- in_ready  out  1  block accepts beat
- in_real  in  DATA_W  signed bin real part
- in_imag  in  DATA_W  signed bin imaginary part
- in_last  in  1  last bin of frame
- out_valid  out  1  averaged band power valid
- out_ready  in  1  consumer accepts result
- out_power  out  PWR_W  unsigned averaged band power
- frame_err  out  1  one-cycle pulse when a malformed frame is dropped

Behaviour:
- Reset: all outputs 0 except in_ready, which is 1 on the first cycle after rst deasserts. Reset clears bin counter, frame counter, accumulators, pipeline and pending result. Reset mid-frame or mid-average discards all partial work.
- Beat accepted when in_valid && in_ready. bin_idx counts 0..NFFT-1 over accepted beats only.
- Config (band_lo, band_hi, avg_log2) is sampled on the first accepted beat of each averaging period (frame count 0, bin_idx 0) and held for that period.
- Pipeline:
  - S1 registers re^2 and im^2 (each 2*DATA_W unsigned; (-2^(DATA_W-1))^2 must be exact).
  - S2 registers mag = re^2 + im^2 (2*DATA_W bits, no overflow), gated by in-band flag: lo <= idx <= hi, else 0.
  - S3 adds into band_sum (PWR_W bits).
- If band_lo > band_hi the band is empty; sum is 0 and output is still produced.
- Frame check, evaluated at acceptance:
  - in_last with bin_idx != NFFT-1, or bin_idx == NFFT-1 without in_last, is an error.
  - On error: frame_err pulses 1 cycle, 3 cycles after the offending beat (aligned with S3). band_sum for that frame is discarded, frame count is not incremented, and bin_idx restarts at 0 on the next beat.
- Good frame: band_sum is added to avg_acc and frame count increments. When frame count reaches 2^avg_log2, the result is set:
  - out_power = avg_acc >> avg_log2 (truncating), out_valid = 1, avg_acc and frame count cleared.
  - Latency from acceptance of the final in_last to out_valid = 4 cycles.
- Output handshake: out_power and out_valid are held stable until out_valid && out_ready; out_valid falls the cycle after.
- Back-pressure: in_ready = 0 from the cycle after the final frame's in_last is accepted until the cycle after the result is accepted. The pipeline drains during this window; no beats are lost.
- avg_log2 = 0 gives one result per good frame.
- Upstream may hold in_valid high across in_ready = 0; data must not advance.

Optional Feature:
- Macro: FFT_BAND_PEAK_EN.
- When defined: extra outputs out_peak_idx [LOG2N] and out_peak_pwr [2*DATA_W], valid with out_valid.
  - Report the in-band bin with the largest mag over the whole averaging period.
  - Tie rule: the earliest frame wins, then the lowest index.
  - Peak trackers reset with avg_acc. Dropped frames do not update them. Empty band reports idx 0, pwr 0.
- When undefined: ports and logic are absent; behaviour otherwise identical.

Test Plan:
- NFFT=8, avg_log2=0, band 0..3, bins k with re=k+1, im=0 -> out_power=1+4+9+16=30, out_valid 4 cycles after in_last.
- Band 4..7, all bins re=im=-2^23 -> each mag=2^47, out_power=2^49 exact, no wrap.
- avg_log2=2, band 2..2, frames with bin2 re = 1,2,3,4 -> (1+4+9+16)>>2 = 7. in_ready low from the 4th in_last until out_ready accepted.
- Frame with in_last at bin 5, then a good frame (band 0..7, all re=1) -> frame_err one pulse, avg_log2=0 result = 8 from the good frame only.
- out_ready held 0 for 10 cycles while in_valid stays 1 -> out_power stable, in_ready 0, no beat consumed. Release -> next frame starts at bin 0.
- rst asserted mid-average (after 2 of 4 frames), then 4 good frames -> result reflects only post-reset frames. Band lo=5, hi=2 -> out_power=0.
